prog_loader: RTL and testbench
==============================

// Module: prog_loader
// PURPOSE
//  Writes a program image into instruction memory before the processor runs.
//  Accepts a byte stream over a valid/ready handshake and packs bytes into instruction words.
//  Writes words to sequential addresses 0..PROG_VALUE-1.
//  Holds the core (cpu_en=0) until the image is complete; the program counter then fetches what was written here.
// PARAMETERS
//  PROG_VALUE   8   number of instruction words in the image; >=2
//  INSTR_WIDTH  16  instruction word width in bits; multiple of 8, >=8
// PORTS
//  clk        in   1                    clock, rising edge
//  rst_n      in   1                    asynchronous, active-low reset
//  start      in   1                    1-cycle pulse: (re)start a load from address 0
//  in_data    in   8                    stream byte
//  in_valid   in   1                    in_data valid
//  in_ready   out  1                    loader can accept a byte this cycle
//  mem_we     out  1                    instruction memory write strobe
//  mem_addr   out  $clog2(PROG_VALUE)   write address
//  mem_wdata  out  INSTR_WIDTH          write data
//  busy       out  1                    load in progress (COLLECT or WRITE)
//  done       out  1                    full image written
//  cpu_en     out  1                    processor enable; equal to done
// BEHAVIOUR
//  Reset (async): state=IDLE, addr=0, byte_cnt=0, word buffer=0; all outputs 0.
//  Reset mid-load aborts the load; memory contents are not touched.
//  Constants and counters
//   - NB = INSTR_WIDTH/8 bytes per word.
//   - byte_cnt counts 0..NB-1.
//  States
//   IDLE    in_ready=0. start -> COLLECT.
//   COLLECT in_ready=1. Byte accepted on in_valid&&in_ready.
//           Packing is little-endian: byte k goes to bits [8k+7:8k].
//           Accepting byte NB-1 -> WRITE, with byte_cnt cleared.
//   WRITE   Exactly 1 cycle, in_ready=0.
//           mem_we=1, mem_addr=addr, mem_wdata=assembled word.
//           If addr==PROG_VALUE-1 -> DONE, else addr<=addr+1 -> COLLECT.
//   DONE    done=1, cpu_en=1, in_ready=0. Stays here until start or reset.
//  Outputs and timing
//   - mem_we, mem_addr and mem_wdata are registered.
//   - mem_we rises the cycle after the last byte of a word is accepted.
//   - Minimum load time: PROG_VALUE*(NB+1) cycles from the first accepted byte.
//   - busy=1 in COLLECT and WRITE only.
//   - mem_addr holds the last written address when not writing.
//   - mem_wdata holds the last written word when not writing.
//  Boundary conditions
//   - addr never exceeds PROG_VALUE-1; no wrap-around writes past the image.
//   - start in any state (COLLECT, WRITE, DONE included):
//     next state=COLLECT, addr=0, byte_cnt=0, done and cpu_en drop next cycle.
//     start has priority over a concurrent byte accept; that byte is discarded.
//     A WRITE cycle coinciding with start still performs its write.
//   - in_valid while in_ready=0: no byte is consumed; the source must hold the byte.
//   - in_valid gaps in COLLECT: the partial word is retained indefinitely.
// TESTING
//  1 Reset values: assert rst_n=0 mid-cycle -> all outputs 0 immediately (async), state IDLE.
//  2 Full load (defaults): start, then 16 back-to-back bytes 0x00..0x0F ->
//    8 writes, addr0=0x0100 ... addr7=0x0F0E;
//    done=1 and cpu_en=1 the cycle after the 8th write.
//  3 Throttled source: in_valid toggles every other cycle ->
//    identical memory image, no lost or duplicated bytes.
//  4 Restart mid-load: start after 5 bytes ->
//    next bytes are written from addr 0; the earlier partial word is discarded.
//  5 Simultaneous start and accept: byte 0xAA offered together with start ->
//    0xAA is not stored; the first stored byte is the next one.
//  6 Reload from DONE: start -> done=0 and cpu_en=0 next cycle;
//    second image overwrites the first at addr 0..7.

Source files
------------

// File: rtl/prog_loader.sv
// prog_loader: streams bytes over valid/ready, packs them little-endian into
// instruction words and writes words to addresses 0..PROG_VALUE-1.  The core
// is held off (cpu_en=0) until the last word of the image has been written.
module prog_loader #(
  parameter int PROG_VALUE  = 8,
  parameter int INSTR_WIDTH = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [7:0]                    in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic                          mem_we,
  output logic [$clog2(PROG_VALUE)-1:0] mem_addr,
  output logic [INSTR_WIDTH-1:0]        mem_wdata,
  output logic                          busy,
  output logic                          done,
  output logic                          cpu_en
);

  localparam int NB = INSTR_WIDTH / 8;
  localparam int AW = $clog2(PROG_VALUE);
  localparam int BW = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [AW-1:0] LAST_ADDR = AW'(PROG_VALUE - 1);
  localparam logic [BW-1:0] LAST_BYTE = BW'(NB - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    WRITE   = 2'd2,
    DONE    = 2'd3
  } state_t;

  // Registered write port toward instruction memory.
  typedef struct packed {
    logic                   we;
    logic [AW-1:0]          addr;
    logic [INSTR_WIDTH-1:0] data;
  } wr_t;

  state_t             state_q, state_d;
  logic [AW-1:0]      addr_q;
  logic [BW-1:0]      byte_cnt_q;
  logic [NB-1:0][7:0] word_q, word_d;
  wr_t                wr_q;
  logic               take;
  logic               last_byte;
  logic               last_addr;

  // A byte is consumed only in COLLECT; start wins over a concurrent byte,
  // which is then dropped rather than stored into the fresh image.
  assign take      = in_valid && (state_q == COLLECT) && !start;
  assign last_byte = (byte_cnt_q == LAST_BYTE);
  assign last_addr = (addr_q == LAST_ADDR);

  // Current word with the incoming byte merged into its byte lane.
  always_comb begin
    word_d             = word_q;
    word_d[byte_cnt_q] = in_data;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; start restarts from any state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    state_d = IDLE;
      COLLECT: if (take && last_byte) state_d = WRITE;
      WRITE:   state_d = last_addr ? DONE : COLLECT;
      DONE:    state_d = DONE;
      default: state_d = IDLE;
    endcase
    if (start) state_d = COLLECT;
  end

  // Address, byte counter and partial-word buffer.  A restart clears them;
  // the address advances after each WRITE except the last, so it never
  // steps past the end of the image.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q     <= '0;
      byte_cnt_q <= '0;
      word_q     <= '0;
    end else if (start) begin
      addr_q     <= '0;
      byte_cnt_q <= '0;
      word_q     <= '0;
    end else if (take) begin
      word_q     <= word_d;
      byte_cnt_q <= last_byte ? '0 : byte_cnt_q + BW'(1);
    end else if (state_q == WRITE && !last_addr) begin
      addr_q     <= addr_q + AW'(1);
    end
  end

  // Write port: loaded when the final byte of a word is taken so the strobe
  // is high exactly during the WRITE cycle; address/data hold afterwards.
  // A start landing in WRITE does not cancel the already-registered strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
    end else begin
      wr_q.we <= take && last_byte;
      if (take && last_byte) begin
        wr_q.addr <= addr_q;
        wr_q.data <= word_d;
      end
    end
  end

  assign mem_we    = wr_q.we;
  assign mem_addr  = wr_q.addr;
  assign mem_wdata = wr_q.data;

  assign in_ready  = (state_q == COLLECT);
  assign busy      = (state_q == COLLECT) || (state_q == WRITE);
  assign done      = (state_q == DONE);
  assign cpu_en    = done;

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: randomized byte source, a behavioural model of the
// load (byte list -> words -> image) and a per-cycle output comparison.
module tb_prog_loader;

  localparam int PV = 8;
  localparam int IW = 16;
  localparam int NB = IW / 8;
  localparam int AW = $clog2(PV);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [7:0]    in_data = 8'h00;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [IW-1:0] mem_wdata;
  logic          busy;
  logic          done;
  logic          cpu_en;

  prog_loader #(.PROG_VALUE(PV), .INSTR_WIDTH(IW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .busy(busy),
    .done(done), .cpu_en(cpu_en)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  int last_acc_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Instruction memory as seen through the DUT write port.
  logic [IW-1:0] dut_mem [PV];
  initial for (int i = 0; i < PV; i++) dut_mem[i] = '0;
  always @(posedge clk) if (mem_we) dut_mem[mem_addr] <= mem_wdata;

  // Behavioural model: bytes accepted since the last start are grouped NB
  // at a time; each completed group is written one cycle later, and the
  // image is complete once PV groups have been written.
  logic          m_load = 0, m_done = 0, m_pend = 0;
  int            m_cnt = 0, m_words = 0;
  logic [IW-1:0] m_cur = '0, m_lw = '0;
  logic [AW-1:0] m_la = '0;
  logic [IW-1:0] m_mem [PV];
  initial for (int i = 0; i < PV; i++) m_mem[i] = '0;

  initial forever begin
    logic nxt_pend;
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_load = 0; m_done = 0; m_pend = 0; m_cnt = 0; m_words = 0;
      m_cur = '0; m_lw = '0; m_la = '0;
    end else begin
      nxt_pend = 0;
      if (m_pend) m_mem[m_la] = m_lw;
      if (start) begin
        m_load = 1; m_done = 0; m_cnt = 0; m_words = 0; m_cur = '0;
      end else if (m_load && !m_pend && in_valid) begin
        m_cur[8*m_cnt +: 8] = in_data;
        m_cnt++;
        if (m_cnt == NB) begin
          nxt_pend = 1;
          m_la     = AW'(m_words);
          m_lw     = m_cur;
          m_words++;
          m_cnt    = 0;
        end
      end else if (m_pend && m_words == PV) begin
        m_load = 0; m_done = 1;
      end
      m_pend = nxt_pend;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      if (n_err < 40) $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("in_ready",  32'(in_ready),  32'(m_load && !m_pend));
      chk("busy",      32'(busy),      32'(m_load));
      chk("done",      32'(done),      32'(m_done));
      chk("cpu_en",    32'(cpu_en),    32'(m_done));
      chk("mem_we",    32'(mem_we),    32'(m_pend));
      chk("mem_addr",  32'(mem_addr),  32'(m_la));
      chk("mem_wdata", 32'(mem_wdata), 32'(m_lw));
    end
  end

  // mode 0: back-to-back, 1: one idle cycle before each byte, 2: random gaps.
  task automatic send(input logic [7:0] b, input int mode);
    int gap;
    logic acc;
    gap = (mode == 1) ? 1 : (mode == 2) ? int'($urandom_range(0, 2)) : 0;
    repeat (gap) begin in_valid = 0; @(posedge clk); #1; end
    in_valid = 1; in_data = b;
    for (int t = 0; t < 50; t++) begin
      acc = in_ready;
      @(posedge clk); #1;
      if (acc) begin in_valid = 0; last_acc_cyc = cyc; return; end
    end
    in_valid = 0;
    n_cmp++; n_err++;
    $display("FAIL send_timeout: byte %0h not accepted within 50 cycles", b);
  endtask

  task automatic start_pulse(input bit with_byte, input logic [7:0] b);
    start = 1;
    if (with_byte) begin in_valid = 1; in_data = b; end
    @(posedge clk); #1;
    start = 0; in_valid = 0;
  endtask

  task automatic wait_done(output int done_cyc);
    done_cyc = -1;
    for (int t = 0; t < 100; t++) begin
      if (done) begin done_cyc = cyc; return; end
      @(posedge clk); #1;
    end
    n_cmp++; n_err++;
    $display("FAIL done_timeout: done still 0 after 100 cycles");
  endtask

  task automatic check_image();
    for (int i = 0; i < PV; i++) chk("image", 32'(dut_mem[i]), 32'(m_mem[i]));
  endtask

  initial begin
    int first_cyc, dcyc;
    logic [7:0] rb [PV*NB];

    // Watchdog.
    fork
      begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
        $fatal(1);
      end
    join_none

    // 1: reset, then an asynchronous reset in the middle of a load.
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    @(posedge clk); #1;
    start_pulse(0, 8'h00);
    for (int i = 0; i < 3; i++) send(8'h50 + 8'(i), 0);
    @(posedge clk); #3;
    rst_n = 0;
    #1;
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_busy",     32'(busy),     0);
    chk("rst_done",     32'(done),     0);
    chk("rst_cpu_en",   32'(cpu_en),   0);
    chk("rst_mem_we",   32'(mem_we),   0);
    chk("rst_mem_addr", 32'(mem_addr), 0);
    chk("rst_mem_wdata",32'(mem_wdata),0);
    @(posedge clk); #1 rst_n = 1;
    @(posedge clk); #1;

    // 2: full back-to-back load of 0x00..0x0F.
    start_pulse(0, 8'h00);
    for (int i = 0; i < PV*NB; i++) begin
      send(8'(i), 0);
      if (i == 0) first_cyc = last_acc_cyc;
    end
    wait_done(dcyc);
    chk("load_latency", 32'(dcyc - first_cyc), 32'(PV*(NB+1) - 1));
    chk("img2_addr0",  32'(dut_mem[0]), 32'h0100);
    chk("img2_addr7",  32'(dut_mem[7]), 32'h0F0E);
    chk("model_addr0", 32'(m_mem[0]),   32'h0100);
    chk("model_addr7", 32'(m_mem[7]),   32'h0F0E);
    chk("cpu_en_on",   32'(cpu_en),     1);
    check_image();

    // 3: throttled source, same bytes after a reload.
    start_pulse(0, 8'h00);
    for (int i = 0; i < PV*NB; i++) send(8'(i), 1);
    wait_done(dcyc);
    chk("img3_addr3", 32'(dut_mem[3]), 32'h0706);
    chk("img3_addr7", 32'(dut_mem[7]), 32'h0F0E);
    check_image();

    // 4: restart after 5 bytes; the partial image is abandoned.
    start_pulse(0, 8'h00);
    for (int i = 0; i < 5; i++) send(8'hC0 + 8'(i), 0);
    start_pulse(0, 8'h00);
    for (int i = 0; i < PV*NB; i++) send(8'h20 + 8'(i), 0);
    wait_done(dcyc);
    chk("img4_addr0", 32'(dut_mem[0]), 32'h2120);
    chk("img4_addr2", 32'(dut_mem[2]), 32'h2524);
    check_image();

    // 5: start while in COLLECT together with byte 0xAA.
    start_pulse(0, 8'h00);
    start_pulse(1, 8'hAA);
    for (int i = 0; i < PV*NB; i++) send(8'h10 + 8'(i), 0);
    wait_done(dcyc);
    chk("img5_addr0", 32'(dut_mem[0]), 32'h1110);
    chk("img5_addr7", 32'(dut_mem[7]), 32'h1F1E);
    check_image();

    // 6: reload from DONE with a random image.
    start_pulse(0, 8'h00);
    chk("reload_done",   32'(done),   0);
    chk("reload_cpu_en", 32'(cpu_en), 0);
    chk("reload_busy",   32'(busy),   1);
    for (int i = 0; i < PV*NB; i++) begin
      rb[i] = 8'($urandom);
      send(rb[i], 2);
    end
    wait_done(dcyc);
    chk("img6_addr0", 32'(dut_mem[0]), 32'({rb[1], rb[0]}));
    chk("img6_addr7", 32'(dut_mem[7]), 32'({rb[15], rb[14]}));
    check_image();

    // Random loads with occasional restarts, including starts that land on
    // a WRITE cycle and starts carrying a byte.
    for (int r = 0; r < 6; r++) begin
      int pre;
      start_pulse(0, 8'h00);
      pre = int'($urandom_range(0, 2*NB + 1));
      for (int i = 0; i < pre; i++) send(8'($urandom), 2);
      if (pre != 0) start_pulse(1, 8'($urandom));
      for (int i = 0; i < PV*NB; i++) send(8'($urandom), int'($urandom_range(0, 2)));
      wait_done(dcyc);
      check_image();
    end

    // Idle in DONE with stray in_valid: nothing consumed, nothing written.
    in_valid = 1; in_data = 8'h77;
    repeat (4) @(posedge clk);
    #1 in_valid = 0;
    chk("done_hold", 32'(done), 1);
    check_image();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
